// File: rtl/fetch_instruction.sv
// fetch_instruction
//   Fetch stage in front of decode. Owns the PC, keeps one instruction-memory
//   request in flight at a time, parks the returned word in an output register
//   and offers it (with its PC + PC_STEP) to decode over valid/ready.
//   Branch/jump redirects retarget the PC. A pending response is squashed if it
//   belongs to the old path. A sticky halt freezes the stage until reset.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   imem_req/addr       request to instruction memory (held until imem_ready)
//   imem_rdata/ready    one-cycle response pulse with the fetched word
//   instr_out/pc_plus2  instruction and its PC + PC_STEP, valid with instr_valid
//   instr_valid         output register holds a word for decode
//   decode_ready        decode accepts the word when instr_valid is high
//   redirect_en/pc      load a new fetch address
//   halt                stop fetching, sticky until reset
//   err                 sticky flag, set by a redirect to an odd address
module fetch_instruction #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        err
);

  typedef enum logic [2:0] {
    S_ISSUE  = 3'd0,
    S_WAIT   = 3'd1,
    S_FULL   = 3'd2,
    S_SQUASH = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [15:0] NOP = 16'h0800;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_addr;
  logic [15:0] r_instr, w_instr_nxt;
  logic [15:0] r_pc2, w_pc2_nxt;
  logic        r_err, w_err_nxt;

  logic [15:0] w_redir_pc;
  logic [15:0] w_pc_inc;

  // Odd targets are forced to halfword alignment; err records the event.
  assign w_redir_pc = {redirect_pc[15:1], 1'b0};
  assign w_pc_inc   = r_pc + PC_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_ISSUE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_instr <= NOP;
      r_pc2   <= 16'h0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc2   <= w_pc2_nxt;
      r_err   <= w_err_nxt;
      // The request address is captured on the way out of ISSUE so it stays
      // put for the whole request, even if a redirect moves the PC while the
      // old request is still being squashed.
      if (r_state == S_ISSUE) r_addr <= r_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pc2_nxt   = r_pc2;
    w_err_nxt   = r_err;

    unique case (r_state)
      S_ISSUE: begin
        if (redirect_en) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_en) begin
          // A response landing this cycle belongs to the old path: drop it.
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = imem_ready ? S_ISSUE : S_SQUASH;
        end else if (imem_ready) begin
          w_instr_nxt = imem_rdata;
          w_pc2_nxt   = w_pc_inc;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        // A transfer this cycle completes regardless of a redirect; either
        // way the register is free next cycle.
        if (redirect_en) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_ISSUE;
        end else if (decode_ready) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_SQUASH: begin
        if (redirect_en) w_pc_nxt = w_redir_pc;
        // Wait out the stale response before issuing on the new path.
        if (imem_ready) w_state_nxt = S_ISSUE;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_ISSUE;
      end
    endcase

    if (redirect_en && r_state != S_HALT && redirect_pc[0]) w_err_nxt = 1'b1;

    // Halt overrides any redirect or response in the same cycle.
    if (halt) begin
      w_state_nxt = S_HALT;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      w_pc2_nxt   = r_pc2;
      w_err_nxt   = r_err;
    end
  end

  assign imem_req    = (r_state == S_WAIT) || (r_state == S_SQUASH);
  assign imem_addr   = r_addr;
  assign instr_out   = r_instr;
  assign pc_plus2    = r_pc2;
  assign instr_valid = (r_state == S_FULL);
  assign err         = r_err;

endmodule

// File: tb/tb_fetch_instruction.sv
// Bench for fetch_instruction: table-driven vectors for the basic fetch and
// back-pressure sequence, hand-written redirect/halt/wrap sequences, and a
// randomized run checked against a transaction-level model.
module tb_fetch_instruction;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        decode_ready = 1'b1;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;

  logic        imem_req, imem_ready, instr_valid, err;
  logic [15:0] imem_addr, imem_rdata, instr_out, pc_plus2;

  // Second instance exercising PC wrap-around from RESET_PC=FFFE.
  logic        b_req, b_ready, b_valid, b_err;
  logic [15:0] b_addr, b_rdata, b_instr, b_pc2;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cnt = 0;
  int cnt_b = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a * 16'd7 + 16'h1234;
  endfunction

  // Memory responders: ready pulses in the lat-th cycle of a held request.
  always @(posedge clk or negedge rst)
    if (!rst) cnt <= 0;
    else cnt <= (imem_req && !imem_ready) ? cnt + 1 : 0;
  assign imem_ready = imem_req && (cnt == lat - 1);
  assign imem_rdata = imem_ready ? memf(imem_addr) : 16'hDEAD;

  always @(posedge clk or negedge rst)
    if (!rst) cnt_b <= 0;
    else cnt_b <= (b_req && !b_ready) ? cnt_b + 1 : 0;
  assign b_ready = b_req && (cnt_b == 0);
  assign b_rdata = b_ready ? memf(b_addr) : 16'hDEAD;

  fetch_instruction dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr_out(instr_out), .pc_plus2(pc_plus2), .instr_valid(instr_valid),
    .decode_ready(decode_ready), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .halt(halt), .err(err)
  );

  fetch_instruction #(.RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_rdata(b_rdata), .imem_ready(b_ready),
    .instr_out(b_instr), .pc_plus2(b_pc2), .instr_valid(b_valid),
    .decode_ready(1'b1), .redirect_en(1'b0),
    .redirect_pc(16'h0000), .halt(1'b0), .err(b_err)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench at a negedge with rst just released: state ISSUE.
  task automatic do_reset(input int l);
    rst = 1'b0;
    redirect_en = 1'b0;
    halt = 1'b0;
    decode_ready = 1'b1;
    lat = l;
    step();
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        dr;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] instr;
    logic [15:0] pc2;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [15:0] exp_pc;
    logic        exp_err;
    logic [15:0] tgt;
    int          ntx;
    int          seen;

    // Sequential fetch 0,2,4 with latency 1, then 5 cycles of back-pressure.
    tbl[0]  = '{1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0};
    tbl[1]  = '{1'b1, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0, 1'b1, memf(16'h0), 16'h2};
    tbl[3]  = '{1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0};
    tbl[4]  = '{1'b1, 1'b1, 16'h2, 1'b0, 16'h0, 16'h0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0, 1'b1, memf(16'h2), 16'h4};
    tbl[6]  = '{1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0};
    tbl[7]  = '{1'b1, 1'b1, 16'h4, 1'b0, 16'h0, 16'h0};
    for (int i = 8; i <= 12; i++)
      tbl[i] = '{1'b0, 1'b0, 16'h0, 1'b1, memf(16'h4), 16'h6};
    tbl[13] = '{1'b1, 1'b0, 16'h0, 1'b1, memf(16'h4), 16'h6};
    tbl[14] = '{1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0};
    tbl[15] = '{1'b1, 1'b1, 16'h6, 1'b0, 16'h0, 16'h0};

    // Reset values, checked while rst is held low.
    rst = 1'b0;
    step();
    chk("rst_req", {15'h0, imem_req}, 16'h0);
    chk("rst_valid", {15'h0, instr_valid}, 16'h0);
    chk("rst_instr", instr_out, 16'h0800);
    chk("rst_pc2", pc_plus2, 16'h0000);
    chk("rst_err", {15'h0, err}, 16'h0);

    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t%0d_req", i), {15'h0, imem_req}, {15'h0, tbl[i].req});
      chk($sformatf("t%0d_valid", i), {15'h0, instr_valid}, {15'h0, tbl[i].vld});
      if (tbl[i].req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
      if (tbl[i].vld) begin
        chk($sformatf("t%0d_instr", i), instr_out, tbl[i].instr);
        chk($sformatf("t%0d_pc2", i), pc_plus2, tbl[i].pc2);
      end
      decode_ready = tbl[i].dr;
      step();
    end

    // Redirect during the 2nd WAIT cycle with latency 4 squashes the request.
    do_reset(4);
    step();                                 // s1: WAIT, first cycle
    step();                                 // s2: WAIT, second cycle
    redirect_en = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect_en = 1'b0;
    chk("sq_req", {15'h0, imem_req}, 16'h1);
    chk("sq_addr_stable", imem_addr, 16'h0000);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (instr_valid) begin
        chk("sq_stale_valid", {15'h0, instr_valid}, 16'h0);
        seen = 2;
      end else if (imem_req && imem_addr == 16'h0040) begin
        seen = 1;
      end else begin
        step();
      end
    end
    chk("sq_new_addr_seen", seen[15:0], 16'h1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (instr_valid) seen = 1;
      else step();
    end
    chk("sq_valid_seen", seen[15:0], 16'h1);
    chk("sq_instr", instr_out, memf(16'h0040));
    chk("sq_pc2", pc_plus2, 16'h0042);

    // Odd redirect target sets sticky err and is aligned down.
    do_reset(1);
    redirect_en = 1'b1;
    redirect_pc = 16'h0041;
    step();
    redirect_en = 1'b0;
    chk("odd_err", {15'h0, err}, 16'h1);
    step();
    chk("odd_req", {15'h0, imem_req}, 16'h1);
    chk("odd_addr", imem_addr, 16'h0040);
    for (int i = 0; i < 6; i++) step();
    chk("odd_err_sticky", {15'h0, err}, 16'h1);

    // PC wrap on the FFFE instance.
    do_reset(1);
    step();
    chk("wrap_addr0", b_addr, 16'hFFFE);
    step();
    chk("wrap_valid", {15'h0, b_valid}, 16'h1);
    chk("wrap_instr", b_instr, memf(16'hFFFE));
    chk("wrap_pc2", b_pc2, 16'h0000);
    step();
    step();
    chk("wrap_req1", {15'h0, b_req}, 16'h1);
    chk("wrap_addr1", b_addr, 16'h0000);

    // Halt during WAIT, then reset out of halt.
    do_reset(4);
    step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (imem_req || instr_valid) seen++;
      step();
    end
    chk("halt_idle", seen[15:0], 16'h0);
    rst = 1'b0;
    #1;
    chk("halt_rst_err", {15'h0, err}, 16'h0);
    chk("halt_rst_instr", instr_out, 16'h0800);
    step();
    rst = 1'b1;
    step();
    chk("halt_refetch_req", {15'h0, imem_req}, 16'h1);
    chk("halt_refetch_addr", imem_addr, 16'h0000);

    // Randomized run against a transaction model: every delivered word is the
    // memory word at the model's fetch PC; a redirect retargets the stream.
    ntx = 0;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset($urandom_range(1, 4));
      exp_pc = 16'h0000;
      exp_err = 1'b0;
      for (int c = 0; c < 400; c++) begin
        chk("rnd_err", {15'h0, err}, {15'h0, exp_err});
        decode_ready = ($urandom_range(0, 3) != 0);
        redirect_en = ($urandom_range(0, 11) == 0);
        tgt = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0) tgt[0] = 1'b0;
        redirect_pc = tgt;
        if (instr_valid && decode_ready) begin
          chk("rnd_instr", instr_out, memf(exp_pc));
          chk("rnd_pc2", pc_plus2, exp_pc + 16'd2);
          exp_pc = exp_pc + 16'd2;
          ntx++;
        end
        if (redirect_en) begin
          exp_pc = tgt & 16'hFFFE;
          if (tgt[0]) exp_err = 1'b1;
        end
        step();
      end
      redirect_en = 1'b0;
    end
    chk("rnd_progress", {15'h0, ntx > 40}, 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
